// File: rtl/cw_gap_encoder.sv
// cw_gap_encoder: Golomb-Rice codes the gaps of an increasing error-position stream into a serial bitstream
module cw_gap_encoder #(
    parameter int PW = 13,
    parameter int LW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [3:0]    u_in,
    input  logic [4:0]    t_in,
    input  logic          pos_valid,
    input  logic [PW-1:0] pos,
    output logic          pos_ready,
    output logic          bit_valid,
    output logic          bit_out,
    input  logic          bit_ready,
    output logic          done,
    output logic          err,
    output logic [LW-1:0] len
);
    typedef enum logic [2:0] {IDLE, WAIT_POS, UNARY, STOP, REM, FIN} state_t;

    state_t        state_q;
    logic [3:0]    u_q;
    logic [4:0]    t_q;
    logic [4:0]    cnt_q;
    logic [PW-1:0] prev1_q;
    logic [PW-1:0] q_cnt_q;
    logic [PW-1:0] rem_q;
    logic [3:0]    r_cnt_q;
    logic [LW-1:0] len_q;
    logic          err_q;
    logic          bit_valid_q;
    logic          bit_out_q;

    logic [PW-1:0] gap_d;
    logic [PW-1:0] q_d;
    logic [PW-1:0] rem_d;
    logic [LW-1:0] len_d;
    logic          more_d;

    // gap split into quotient/remainder, saturating bit count, and whether positions remain
    always_comb begin
        gap_d  = pos - prev1_q;
        q_d    = gap_d >> u_q;
        rem_d  = gap_d & ~({PW{1'b1}} << u_q);
        len_d  = (bit_valid_q && bit_ready && !(&len_q)) ? len_q + LW'(1) : len_q;
        more_d = cnt_q < t_q;
    end

    // word sequencer: accepts positions, then walks unary ones, the stop zero and the remainder bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            u_q         <= '0;
            t_q         <= '0;
            cnt_q       <= '0;
            prev1_q     <= '0;
            q_cnt_q     <= '0;
            rem_q       <= '0;
            r_cnt_q     <= '0;
            len_q       <= '0;
            err_q       <= 1'b0;
            bit_valid_q <= 1'b0;
            bit_out_q   <= 1'b0;
        end else begin
            len_q <= len_d;
            case (state_q)
                IDLE: if (start) begin
                    u_q     <= u_in;
                    t_q     <= t_in;
                    prev1_q <= '0;
                    cnt_q   <= '0;
                    len_q   <= '0;
                    err_q   <= 1'b0;
                    state_q <= (t_in == 5'd0) ? FIN : WAIT_POS;
                end
                WAIT_POS: if (pos_valid) begin
                    if (pos < prev1_q) begin
                        err_q   <= 1'b1;
                        state_q <= FIN;
                    end else begin
                        prev1_q     <= pos + PW'(1);
                        cnt_q       <= cnt_q + 5'd1;
                        q_cnt_q     <= q_d;
                        rem_q       <= rem_d;
                        r_cnt_q     <= u_q;
                        bit_valid_q <= 1'b1;
                        bit_out_q   <= (q_d != '0);
                        state_q     <= (q_d != '0) ? UNARY : STOP;
                    end
                end
                UNARY: if (bit_ready) begin
                    q_cnt_q <= q_cnt_q - PW'(1);
                    if (q_cnt_q == PW'(1)) begin
                        bit_out_q <= 1'b0;
                        state_q   <= STOP;
                    end
                end
                STOP: if (bit_ready) begin
                    if (u_q != 4'd0) begin
                        bit_out_q <= rem_q[u_q - 4'd1];
                        state_q   <= REM;
                    end else begin
                        bit_valid_q <= 1'b0;
                        state_q     <= more_d ? WAIT_POS : FIN;
                    end
                end
                REM: if (bit_ready) begin
                    r_cnt_q <= r_cnt_q - 4'd1;
                    if (r_cnt_q == 4'd1) begin
                        bit_valid_q <= 1'b0;
                        bit_out_q   <= 1'b0;
                        state_q     <= more_d ? WAIT_POS : FIN;
                    end else begin
                        bit_out_q <= rem_q[r_cnt_q - 4'd2];
                    end
                end
                FIN: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pos_ready = (state_q == WAIT_POS);
    assign done      = (state_q == FIN);
    assign bit_valid = bit_valid_q;
    assign bit_out   = bit_out_q;
    assign err       = err_q;
    assign len       = len_q;
endmodule

// File: tb/tb_cw_gap_encoder.sv
// tb_cw_gap_encoder: table-driven words with a bit scoreboard, plus reset-during-unary sequence
module tb_cw_gap_encoder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  u_in;
    logic [4:0]  t_in;
    logic        pos_valid;
    logic [12:0] pos;
    logic        pos_ready;
    logic        bit_valid;
    logic        bit_out;
    logic        bit_ready;
    logic        done;
    logic        err;
    logic [15:0] len;

    cw_gap_encoder #(.PW(13), .LW(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .u_in(u_in), .t_in(t_in),
        .pos_valid(pos_valid), .pos(pos), .pos_ready(pos_ready),
        .bit_valid(bit_valid), .bit_out(bit_out), .bit_ready(bit_ready),
        .done(done), .err(err), .len(len)
    );

    always #5 clk = ~clk;

    typedef struct {
        int              u;
        int              t;
        int              n;
        logic [2:0][12:0] p;
        bit              stall;
        int              exp_len;
        int              exp_err;
    } vec_t;

    vec_t tbl[8];
    bit   exp_q[$];
    int   checks = 0;
    int   fails = 0;
    int   done_cnt, pr_seen, got_len, got_err, mprev;
    bit   merr, hold_v, hold_b;

    function automatic vec_t mk(int u, int t, int n, int p0, int p1, int p2, bit s, int l, int e);
        vec_t v;
        v.u = u; v.t = t; v.n = n; v.stall = s; v.exp_len = l; v.exp_err = e;
        v.p[0] = 13'(p0); v.p[1] = 13'(p1); v.p[2] = 13'(p2);
        return v;
    endfunction

    task automatic chk(string nm, int act, int expv);
        checks++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, expv);
        end
    endtask

    task automatic model(int u, int p);
        int gap;
        if (merr) return;
        if (p < mprev) begin
            merr = 1'b1;
            return;
        end
        gap = p - mprev;
        repeat (gap >> u) exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        for (int k = u - 1; k >= 0; k--) exp_q.push_back(1'((gap >> k) & 1));
        mprev = p + 1;
    endtask

    task automatic cyc();
        bit e;
        if (hold_v) chk("stall_stable", int'(bit_out), int'(hold_b));
        if (bit_valid && bit_ready) begin
            if (exp_q.size() == 0) chk("extra_bit", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("bit", int'(bit_out), int'(e));
            end
        end
        hold_v = bit_valid && !bit_ready;
        hold_b = bit_out;
        if (pos_ready) pr_seen++;
        if (done) begin
            done_cnt++;
            got_len = int'(len);
            got_err = int'(err);
        end
        @(negedge clk);
    endtask

    task automatic run_word(int i);
        vec_t v;
        int pi, cycles;
        bit acc;
        v = tbl[i];
        exp_q.delete();
        mprev = 0; merr = 1'b0; done_cnt = 0; pr_seen = 0; hold_v = 1'b0;
        start = 1'b1; u_in = 4'(v.u); t_in = 5'(v.t); pos_valid = 1'b0; bit_ready = 1'b1;
        cyc();
        start = 1'b0;
        pi = 0; cycles = 0;
        while (done_cnt == 0 && cycles < 3000) begin
            pos_valid = (pi < v.n);
            pos = (pi < 3) ? v.p[pi] : 13'd0;
            bit_ready = v.stall ? (cycles % 4 == 3) : 1'b1;
            acc = pos_valid && pos_ready;
            cyc();
            cycles++;
            if (acc) begin
                model(v.u, int'(v.p[pi]));
                pi++;
            end
        end
        chk($sformatf("w%0d_done", i), done_cnt, 1);
        chk($sformatf("w%0d_len", i), got_len, v.exp_len);
        chk($sformatf("w%0d_err", i), got_err, v.exp_err);
        chk($sformatf("w%0d_bits_left", i), exp_q.size(), 0);
        if (v.t == 0) begin
            chk($sformatf("w%0d_t0_latency", i), cycles, 1);
            chk($sformatf("w%0d_t0_pos_ready", i), pr_seen, 0);
        end
        pos_valid = 1'b0;
        bit_ready = 1'b1;
        cyc();
        chk($sformatf("w%0d_done_pulse", i), done_cnt, 1);
        chk($sformatf("w%0d_pos_ready_low", i), int'(pos_ready), 0);
        chk($sformatf("w%0d_len_hold", i), int'(len), v.exp_len);
    endtask

    initial begin
        tbl[0] = mk(2, 2, 2, 5, 9, 0, 1'b0, 7, 0);
        tbl[1] = mk(0, 1, 1, 3, 0, 0, 1'b0, 4, 0);
        tbl[2] = mk(2, 2, 2, 5, 5, 0, 1'b0, 4, 1);
        tbl[3] = mk(2, 1, 1, 1, 0, 0, 1'b1, 3, 0);
        tbl[4] = mk(0, 0, 0, 0, 0, 0, 1'b0, 0, 0);
        tbl[5] = mk(12, 1, 1, 4899, 0, 0, 1'b0, 14, 0);
        tbl[6] = mk(3, 3, 3, 0, 1, 20, 1'b0, 14, 0);
        tbl[7] = mk(0, 2, 2, 0, 4, 0, 1'b1, 5, 0);
        rst_n = 1'b0; start = 1'b0; u_in = '0; t_in = '0;
        pos_valid = 1'b0; pos = '0; bit_ready = 1'b0;
        hold_v = 1'b0;
        #1;
        chk("rst_pos_ready", int'(pos_ready), 0);
        chk("rst_bit_valid", int'(bit_valid), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_len", int'(len), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) run_word(i);

        exp_q.delete();
        mprev = 0; merr = 1'b0; done_cnt = 0; hold_v = 1'b0;
        start = 1'b1; u_in = 4'd0; t_in = 5'd1; bit_ready = 1'b1;
        cyc();
        start = 1'b0; pos_valid = 1'b1; pos = 13'd20;
        cyc();
        model(0, 20);
        pos_valid = 1'b0;
        repeat (3) cyc();
        chk("pre_rst_bit_valid", int'(bit_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_bit_valid", int'(bit_valid), 0);
        chk("arst_bit_out", int'(bit_out), 0);
        chk("arst_pos_ready", int'(pos_ready), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_err", int'(err), 0);
        chk("arst_len", int'(len), 0);
        @(negedge clk);
        exp_q.delete();
        hold_v = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
        repeat (2) cyc();
        chk("arst_no_done", done_cnt, 0);
        run_word(0);
        run_word(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
